// File: rtl/llr_frame_encoder_pkg.sv
// Shared dimensions and the systematic generator table for the LLR frame encoder.
// The parity rows come from the (15,7) cyclic code g(x) = x^8+x^7+x^6+x^4+1.
package llr_frame_encoder_pkg;

  localparam int INT_SIZE    = 8;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_N_V     = 15;
  localparam int DEF_K       = 7;
  localparam int DEF_LLR_MAG = 7;

  // Row i holds x^(P+i) mod g(x); the same source feeds the decoder's H construction.
  function automatic logic [15:0] gen_row_default(input logic [INT_SIZE-1:0] idx);
    logic [15:0] row;
    case (idx)
      8'd0:    row = 16'h00D1;
      8'd1:    row = 16'h0073;
      8'd2:    row = 16'h00E6;
      8'd3:    row = 16'h001D;
      8'd4:    row = 16'h003A;
      8'd5:    row = 16'h0074;
      8'd6:    row = 16'h00E8;
      default: row = '0;
    endcase
    return row;
  endfunction

endpackage

// File: rtl/llr_frame_encoder_lut_generator.sv
// Combinational ROM returning the parity part of generator row gen_idx.
module lut_generator
  import llr_frame_encoder_pkg::*;
#(
  parameter int N_V = DEF_N_V,
  parameter int K   = DEF_K
) (
  input  logic [INT_SIZE-1:0] gen_idx,
  output logic [N_V-K-1:0]    gen_row
);

  localparam int P = N_V - K;

  always_comb begin
    gen_row = P'(gen_row_default(gen_idx));
  end

endmodule

// File: rtl/llr_frame_encoder.sv
// Serial systematic encoder: accumulates K message bits, then holds the codeword
// as hard bits and as BPSK-mapped LLRs until the downstream takes it.
module llr_frame_encoder
  import llr_frame_encoder_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int N_V     = DEF_N_V,
  parameter int K       = DEF_K,
  parameter int LLR_MAG = DEF_LLR_MAG
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_bit,
  input  logic                 in_sop,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_V-1:0]       out_bits,
  output logic [WIDTH*N_V-1:0] all_llrs
);

  localparam int P  = N_V - K;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  localparam logic [WIDTH-1:0] POS_MAG = WIDTH'(LLR_MAG);
  localparam logic [WIDTH-1:0] NEG_MAG = ~POS_MAG + 1'b1;

  logic [0:0]          state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt, idx;
  logic [K-1:0]        msg, msg_nxt;
  logic [P-1:0]        parity, parity_nxt, gen_row;
  logic [INT_SIZE-1:0] gen_idx;
  logic [WIDTH*N_V-1:0] llr_nxt;

  lut_generator #(.N_V(N_V), .K(K)) u_lut (
    .gen_idx(gen_idx),
    .gen_row(gen_row)
  );

  assign in_ready = (state == ACCUM);
  assign out_bits = {parity, msg};

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    msg_nxt    = msg;
    parity_nxt = parity;
    idx        = in_sop ? '0 : cnt;
    gen_idx    = INT_SIZE'(idx);
    if (state == ACCUM) begin
      if (in_valid) begin
        // A start-of-packet drops whatever partial frame was in flight.
        msg_nxt      = in_sop ? '0 : msg;
        msg_nxt[idx] = in_bit;
        parity_nxt   = (in_sop ? '0 : parity) ^ (in_bit ? gen_row : '0);
        if (idx == CW'(K - 1)) begin
          cnt_nxt   = '0;
          state_nxt = HOLD;
        end else begin
          cnt_nxt = idx + CW'(1);
        end
      end
    end else if (out_ready) begin
      msg_nxt    = '0;
      parity_nxt = '0;
      state_nxt  = ACCUM;
    end
  end

  always_comb begin
    llr_nxt = '0;
    for (int unsigned j = 0; j < N_V; j++) begin
      llr_nxt[WIDTH*j +: WIDTH] = (j < K) ? (msg_nxt[j] ? NEG_MAG : POS_MAG)
                                          : (parity_nxt[j-K] ? NEG_MAG : POS_MAG);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      cnt       <= '0;
      msg       <= '0;
      parity    <= '0;
      out_valid <= 1'b0;
      all_llrs  <= {N_V{POS_MAG}};
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      msg       <= msg_nxt;
      parity    <= parity_nxt;
      out_valid <= (state_nxt == HOLD);
      all_llrs  <= llr_nxt;
    end
  end

endmodule
